// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Round-robin arbiter for the Common Data Bus of the Tomasulo datapath.
//   Grants at most one finished functional-unit result per cycle and
//   broadcasts it one cycle later as a (Qi_CDB, Qi_CDB_data) pair, together
//   with the destination register and a one-hot per-station write enable.
//
// Ports
//   Clock        in   rising-edge clock
//   Reset        in   asynchronous, active-high reset
//   Flush        in   suppresses the grant in the current cycle
//   Req_valid    in   [N_REQ]        unit i holds a finished result
//   Req_data     in   [N_REQ*DATA_W] result of unit i at [i*DATA_W +: DATA_W]
//   Req_reg      in   [N_REQ*REG_W]  destination register of unit i
//   Req_ready    out  [N_REQ]        combinational grant, one-hot or zero
//   CDB_valid    out  broadcast valid
//   Qi_CDB       out  [TAG_W]  broadcasting station tag (i+1), IDLE_TAG if idle
//   Qi_CDB_data  out  [DATA_W] broadcast result (held while idle)
//   CDB_reg      out  [REG_W]  destination register of the broadcast
//   R_enable     out  [N_REQ]  one-hot station write enable, aligned with CDB_valid
//   Bcast_count  out  [16]     broadcasts since reset, wrapping
module cdb_arbiter #(
    parameter int unsigned           N_REQ    = 3,
    parameter int unsigned           TAG_W    = 4,
    parameter int unsigned           DATA_W   = 16,
    parameter int unsigned           REG_W    = 3,
    parameter logic [TAG_W-1:0]      IDLE_TAG = '0
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      Flush,
    input  logic [N_REQ-1:0]          Req_valid,
    input  logic [N_REQ*DATA_W-1:0]   Req_data,
    input  logic [N_REQ*REG_W-1:0]    Req_reg,
    output logic [N_REQ-1:0]          Req_ready,
    output logic                      CDB_valid,
    output logic [TAG_W-1:0]          Qi_CDB,
    output logic [DATA_W-1:0]         Qi_CDB_data,
    output logic [REG_W-1:0]          CDB_reg,
    output logic [N_REQ-1:0]          R_enable,
    output logic [15:0]               Bcast_count
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0]  rr_ptr;
    logic [N_REQ-1:0]  grant;
    logic              found;
    int unsigned       scan_pos;
    int unsigned       sel_idx;
    logic [PTR_W-1:0]  scan_bit;
    logic [DATA_W-1:0] sel_data;
    logic [REG_W-1:0]  sel_reg;

    // Scan from rr_ptr upward (mod N_REQ); first valid requester wins.
    always_comb begin
        grant    = '0;
        found    = 1'b0;
        scan_pos = 0;
        scan_bit = '0;
        sel_idx  = 0;
        sel_data = '0;
        sel_reg  = '0;
        if (!Reset && !Flush) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                scan_pos = (32'(rr_ptr) + k) % N_REQ;
                scan_bit = PTR_W'(scan_pos);
                if (!found && Req_valid[scan_bit]) begin
                    found          = 1'b1;
                    grant[scan_bit] = 1'b1;
                    sel_idx        = scan_pos;
                    sel_data       = DATA_W'(Req_data >> (scan_pos * DATA_W));
                    sel_reg        = REG_W'(Req_reg >> (scan_pos * REG_W));
                end
            end
        end
    end

    assign Req_ready = grant;

    // A grant is only ever given to a valid requester, so found marks a transfer.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            CDB_valid   <= 1'b0;
            Qi_CDB      <= IDLE_TAG;
            Qi_CDB_data <= '0;
            CDB_reg     <= '0;
            R_enable    <= '0;
            Bcast_count <= '0;
            rr_ptr      <= '0;
        end else if (found) begin
            CDB_valid   <= 1'b1;
            Qi_CDB      <= TAG_W'(sel_idx + 1);
            Qi_CDB_data <= sel_data;
            CDB_reg     <= sel_reg;
            R_enable    <= grant;
            Bcast_count <= Bcast_count + 16'd1;
            rr_ptr      <= PTR_W'((sel_idx + 1) % N_REQ);
        end else begin
            // Idle cycle: data bus keeps its last value.
            CDB_valid   <= 1'b0;
            Qi_CDB      <= IDLE_TAG;
            CDB_reg     <= '0;
            R_enable    <= '0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
//   Directed self-checking bench for cdb_arbiter: single grant, rotation,
//   pointer-based priority, flush, asynchronous reset mid-broadcast and
//   broadcast counter wrap.
module tb_cdb_arbiter;

    logic        Clock;
    logic        Reset;
    logic        Flush;
    logic [2:0]  Req_valid;
    logic [47:0] Req_data;
    logic [8:0]  Req_reg;
    logic [2:0]  Req_ready;
    logic        CDB_valid;
    logic [3:0]  Qi_CDB;
    logic [15:0] Qi_CDB_data;
    logic [2:0]  CDB_reg;
    logic [2:0]  R_enable;
    logic [15:0] Bcast_count;

    int unsigned checks = 0;
    int unsigned errors = 0;

    cdb_arbiter #(
        .N_REQ   (3),
        .TAG_W   (4),
        .DATA_W  (16),
        .REG_W   (3),
        .IDLE_TAG(4'd0)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Flush      (Flush),
        .Req_valid  (Req_valid),
        .Req_data   (Req_data),
        .Req_reg    (Req_reg),
        .Req_ready  (Req_ready),
        .CDB_valid  (CDB_valid),
        .Qi_CDB     (Qi_CDB),
        .Qi_CDB_data(Qi_CDB_data),
        .CDB_reg    (CDB_reg),
        .R_enable   (R_enable),
        .Bcast_count(Bcast_count)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int unsigned i, input logic [15:0] d, input logic [2:0] r);
        Req_data[i*16 +: 16] = d;
        Req_reg[i*3 +: 3]    = r;
    endtask

    task automatic edge_sample();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset     = 1'b1;
        Flush     = 1'b0;
        Req_valid = 3'b001;
        Req_data  = '0;
        Req_reg   = '0;
        set_req(0, 16'h0005, 3'd2);

        // Reset state; grant suppressed while Reset is high
        #12;
        check("rst_ready", Req_ready, 3'b000);
        check("rst_valid", CDB_valid, 1'b0);
        check("rst_tag", Qi_CDB, 4'd0);
        check("rst_data", Qi_CDB_data, 16'h0000);
        check("rst_renable", R_enable, 3'b000);
        check("rst_count", Bcast_count, 16'd0);

        // 1: single request from unit 0
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        check("t1_ready", Req_ready, 3'b001);
        edge_sample();
        Req_valid = 3'b000;
        check("t1_valid", CDB_valid, 1'b1);
        check("t1_tag", Qi_CDB, 4'd1);
        check("t1_data", Qi_CDB_data, 16'h0005);
        check("t1_reg", CDB_reg, 3'd2);
        check("t1_renable", R_enable, 3'b001);
        check("t1_count", Bcast_count, 16'd1);
        edge_sample();
        check("t1_idle_tag", Qi_CDB, 4'd0);
        check("t1_idle_valid", CDB_valid, 1'b0);
        check("t1_idle_reg", CDB_reg, 3'd0);
        check("t1_idle_renable", R_enable, 3'b000);
        check("t1_idle_hold", Qi_CDB_data, 16'h0005);

        // 3: rr_ptr is 1, so unit 2 beats unit 0
        set_req(0, 16'hAAAA, 3'd3);
        set_req(2, 16'hCCCC, 3'd5);
        Req_valid = 3'b101;
        #1;
        check("t3_ready_a", Req_ready, 3'b100);
        edge_sample();
        Req_valid = 3'b001;
        check("t3_tag_a", Qi_CDB, 4'd3);
        check("t3_data_a", Qi_CDB_data, 16'hCCCC);
        check("t3_reg_a", CDB_reg, 3'd5);
        check("t3_renable_a", R_enable, 3'b100);
        check("t3_ready_b", Req_ready, 3'b001);
        edge_sample();
        check("t3_tag_b", Qi_CDB, 4'd1);
        check("t3_data_b", Qi_CDB_data, 16'hAAAA);
        check("t3_reg_b", CDB_reg, 3'd3);
        check("t3_count", Bcast_count, 16'd3);

        // 4: flush blocks the grant; the broadcast already on the bus stays
        Flush     = 1'b1;
        Req_valid = 3'b010;
        set_req(1, 16'h1111, 3'd6);
        #1;
        check("t4_flush_ready", Req_ready, 3'b000);
        check("t4_flush_bus", Qi_CDB, 4'd1);
        edge_sample();
        check("t4_idle_valid", CDB_valid, 1'b0);
        check("t4_idle_tag", Qi_CDB, 4'd0);
        check("t4_idle_count", Bcast_count, 16'd3);
        Flush = 1'b0;
        #1;
        check("t4_ready", Req_ready, 3'b010);
        edge_sample();
        check("t4_tag", Qi_CDB, 4'd2);
        check("t4_data", Qi_CDB_data, 16'h1111);
        check("t4_reg", CDB_reg, 3'd6);
        check("t4_renable", R_enable, 3'b010);
        check("t4_count", Bcast_count, 16'd4);

        // 5: reset while a broadcast is on the bus
        set_req(1, 16'h2222, 3'd1);
        edge_sample();
        check("t5_pre_valid", CDB_valid, 1'b1);
        check("t5_pre_tag", Qi_CDB, 4'd2);
        Reset = 1'b1;
        #1;
        check("t5_valid", CDB_valid, 1'b0);
        check("t5_tag", Qi_CDB, 4'd0);
        check("t5_renable", R_enable, 3'b000);
        check("t5_count", Bcast_count, 16'd0);
        check("t5_ready", Req_ready, 3'b000);
        Req_valid = 3'b110;
        set_req(2, 16'h3333, 3'd7);
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        check("t5_first_ready", Req_ready, 3'b010);
        edge_sample();
        check("t5_first_tag", Qi_CDB, 4'd2);
        check("t5_first_count", Bcast_count, 16'd1);

        // 2: all three request continuously from reset -> 1,2,3,1
        Reset = 1'b1;
        set_req(0, 16'h0100, 3'd1);
        set_req(1, 16'h0200, 3'd2);
        set_req(2, 16'h0300, 3'd3);
        Req_valid = 3'b111;
        @(negedge Clock);
        Reset = 1'b0;
        edge_sample();
        check("t2_tag0", Qi_CDB, 4'd1);
        check("t2_data0", Qi_CDB_data, 16'h0100);
        edge_sample();
        check("t2_tag1", Qi_CDB, 4'd2);
        check("t2_valid1", CDB_valid, 1'b1);
        edge_sample();
        check("t2_tag2", Qi_CDB, 4'd3);
        check("t2_valid2", CDB_valid, 1'b1);
        edge_sample();
        check("t2_tag3", Qi_CDB, 4'd1);
        check("t2_valid3", CDB_valid, 1'b1);
        check("t2_count", Bcast_count, 16'd4);

        // 6: counter wrap after 65536 back-to-back transfers
        repeat (65535 - 4) edge_sample();
        check("t6_count_max", Bcast_count, 16'hFFFF);
        check("t6_tag_max", Qi_CDB, 4'd3);
        edge_sample();
        check("t6_count_wrap", Bcast_count, 16'h0000);
        check("t6_tag_wrap", Qi_CDB, 4'd1);
        check("t6_valid_wrap", CDB_valid, 1'b1);

        Req_valid = 3'b000;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
